// File: rtl/inst_rx_pkg.sv
// Shared definitions for the instruct receive path.
// The PCM receiver and the instruct RX control block both use them.
//   rx_state_t    : receiver FSM encoding (HUNT / PAYLOAD)
//   INST_MAX_BITS : width of the assembled instruction word
//   LEN_CLAMP     : effective length used when cfg_ins_length is 0 or too large
//   clamp_len()   : maps cfg_ins_length onto the effective frame length
package inst_rx_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } rx_state_t;

    localparam int INST_MAX_BITS = 512;
    localparam int LEN_W         = 10;   // holds 1..512
    localparam logic [LEN_W-1:0] LEN_CLAMP = 10'd512;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] len);
        if (len == 16'd0 || len > 16'(INST_MAX_BITS)) begin
            return LEN_CLAMP;
        end
        return len[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/inst_sync_det.sv
// Frame sync hunter: shifts each qualified bit into a SYNC_WIDTH-bit register
// (MSB received first) and flags a match once at least SYNC_WIDTH bits have
// arrived since the last clear.
//   clk_sys   : system clock
//   rst       : synchronous active-high reset
//   clr       : synchronous clear of shift register and fill counter
//   bit_valid : strobe qualifying bit_in
//   bit_in    : received bit
//   sync_word : pattern to match
//   sync_hit  : combinational, high in the strobe cycle that completes a match
module inst_sync_det #(
    parameter int SYNC_WIDTH = 32
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    input  logic [SYNC_WIDTH-1:0] sync_word,
    output logic                  sync_hit
);

    localparam int FILL_W = $clog2(SYNC_WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_WIDTH);

    logic [SYNC_WIDTH-1:0] sreg;
    logic [SYNC_WIDTH-1:0] sreg_nxt;
    logic [FILL_W-1:0]     fill;
    logic [FILL_W-1:0]     fill_nxt;

    // Truncating the concatenation drops the oldest bit; also works for width 1.
    assign sreg_nxt = SYNC_WIDTH'({sreg, bit_in});
    assign fill_nxt = (fill == FILL_FULL) ? fill : fill + 1'b1;

    // The comparison includes the bit arriving this cycle.
    assign sync_hit = bit_valid && !clr && (fill_nxt == FILL_FULL) && (sreg_nxt == sync_word);

    always_ff @(posedge clk_sys) begin
        if (rst || clr) begin
            sreg <= '0;
            fill <= '0;
        end else if (bit_valid) begin
            sreg <= sreg_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/inst_pcm2rx.sv
// PCM-to-instruction receiver. Hunts for the sync word, then assembles
// len_eff payload bits MSB-first into a 512-bit word.
//   clk_sys           : system clock
//   rst               : synchronous active-high reset
//   cfg_rx_en         : receiver enable, low forces HUNT and drops partial frames
//   cfg_sync_word     : sync pattern, MSB received first
//   cfg_ins_length    : payload length in bits (0 or >512 means 512)
//   pcm_rx_bit        : received bit
//   pcm_rx_bit_valid  : strobe qualifying pcm_rx_bit
//   pcm_rx_data       : last completed instruction, first payload bit in [511]
//   pcm_rx_data_valid : one-cycle pulse on frame completion
//   pcm_rx_err        : one-cycle pulse on payload bit-gap timeout
//   pcm_rx_busy       : registered copy of (state == PAYLOAD); doubles as FSM state view
//
// Handshake: pcm_rx_bit is consumed in every cycle where pcm_rx_bit_valid is
// high; there is no back-pressure. pcm_rx_data_valid is a single-cycle pulse
// with no ready, and pcm_rx_data stays stable until the next completion.
module inst_pcm2rx
    import inst_rx_pkg::*;
#(
    parameter int U_DLY       = 1,
    parameter int SYNC_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     cfg_rx_en,
    input  logic [SYNC_WIDTH-1:0]    cfg_sync_word,
    input  logic [15:0]              cfg_ins_length,
    input  logic                     pcm_rx_bit,
    input  logic                     pcm_rx_bit_valid,
    output logic [INST_MAX_BITS-1:0] pcm_rx_data,
    output logic                     pcm_rx_data_valid,
    output logic                     pcm_rx_err,
    output logic                     pcm_rx_busy
);

    localparam int GAP_W = $clog2(TIMEOUT_CYC);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 1);

    // Register delay is modelled as zero in this synthesizable form.
    if (U_DLY < 0) begin : g_u_dly_unused
    end

    rx_state_t              state;
    logic [8:0]             bit_cnt;
    logic [LEN_W-1:0]       len_lat;
    logic [GAP_W-1:0]       gap_cnt;
    logic [INST_MAX_BITS-1:0] asm_buf;
    logic [INST_MAX_BITS-1:0] buf_wr;
    logic                   sync_hit;
    logic                   sync_clr;
    logic                   last_bit;

    // The hunter only runs in HUNT; holding it cleared elsewhere also gives the
    // "cleared on return to HUNT" behaviour for free.
    assign sync_clr = (state == PAYLOAD) || !cfg_rx_en;

    inst_sync_det #(
        .SYNC_WIDTH (SYNC_WIDTH)
    ) u_sync_det (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .clr       (sync_clr),
        .bit_valid (pcm_rx_bit_valid),
        .bit_in    (pcm_rx_bit),
        .sync_word (cfg_sync_word),
        .sync_hit  (sync_hit)
    );

    // Buffer with the current bit merged in, so the last bit reaches the output.
    always_comb begin
        buf_wr = asm_buf;
        buf_wr[9'd511 - bit_cnt] = pcm_rx_bit;
    end

    assign last_bit = ({1'b0, bit_cnt} == (len_lat - 1'b1));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state             <= HUNT;
            bit_cnt           <= '0;
            len_lat           <= LEN_CLAMP;
            gap_cnt           <= '0;
            asm_buf           <= '0;
            pcm_rx_data       <= '0;
            pcm_rx_data_valid <= 1'b0;
            pcm_rx_err        <= 1'b0;
            pcm_rx_busy       <= 1'b0;
        end else begin
            pcm_rx_data_valid <= 1'b0;
            pcm_rx_err        <= 1'b0;
            if (!cfg_rx_en) begin
                state       <= HUNT;
                bit_cnt     <= '0;
                gap_cnt     <= '0;
                pcm_rx_busy <= 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        if (sync_hit) begin
                            state       <= PAYLOAD;
                            pcm_rx_busy <= 1'b1;
                            bit_cnt     <= '0;
                            gap_cnt     <= '0;
                            asm_buf     <= '0;
                            len_lat     <= clamp_len(cfg_ins_length);
                        end
                    end
                    PAYLOAD: begin
                        if (pcm_rx_bit_valid) begin
                            // A strobe at the gap limit still counts as on time.
                            gap_cnt <= '0;
                            if (last_bit) begin
                                pcm_rx_data       <= buf_wr;
                                pcm_rx_data_valid <= 1'b1;
                                state             <= HUNT;
                                pcm_rx_busy       <= 1'b0;
                            end else begin
                                asm_buf <= buf_wr;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (gap_cnt == GAP_LIMIT) begin
                            pcm_rx_err  <= 1'b1;
                            state       <= HUNT;
                            pcm_rx_busy <= 1'b0;
                            gap_cnt     <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
